// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: tiles one fully-connected binary-weight layer over a
// combinational datapath. Walks input tiles (k) inside output tiles (o),
// issues reads to the input buffer and weight memory, and accumulates the
// per-tile partial sums into wide signed per-lane accumulators. Each finished
// output tile is offered on a valid/ready stream.
//
// Build option: define SEQ_SATURATE_EN to clamp each output lane to the signed
// BIT_CNT range; otherwise each lane is the low BIT_CNT bits of its
// accumulator (two's-complement wrap).
module bnn_layer_sequencer #(
    parameter int INPUT_DIM     = 16,
    parameter int OUTPUT_DIM    = 8,
    parameter int BIT_CNT       = 8,
    parameter int MAX_IN_TILES  = 16,
    parameter int MAX_OUT_TILES = 16,
    parameter int ACC_BIT       = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [$clog2(MAX_IN_TILES):0]                 cfg_in_tiles,
    input  logic [$clog2(MAX_OUT_TILES):0]                cfg_out_tiles,
    output logic                                          rd_en,
    output logic [$clog2(MAX_IN_TILES)-1:0]               in_addr,
    output logic [$clog2(MAX_IN_TILES*MAX_OUT_TILES)-1:0] w_addr,
    input  logic [OUTPUT_DIM*BIT_CNT-1:0]                 dp_result,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [OUTPUT_DIM*BIT_CNT-1:0]                 out_data,
    output logic [$clog2(MAX_OUT_TILES)-1:0]              out_tile,
    output logic                                          busy,
    output logic                                          done
);

    localparam int IN_AW  = $clog2(MAX_IN_TILES);
    localparam int OUT_AW = $clog2(MAX_OUT_TILES);
    localparam int W_AW   = $clog2(MAX_IN_TILES*MAX_OUT_TILES);
    localparam int NI_W   = IN_AW + 1;
    localparam int NO_W   = OUT_AW + 1;

    // Reject parameter sets where the accumulator cannot hold a full layer.
    generate
        if (INPUT_DIM < 1 || ACC_BIT < BIT_CNT + $clog2(MAX_IN_TILES)) begin : g_bad_cfg
            $error("bnn_layer_sequencer: ACC_BIT too narrow or INPUT_DIM < 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [NI_W-1:0]                 n_q, n_d;
    logic [NO_W-1:0]                 m_q, m_d;
    logic [IN_AW-1:0]                k_q, k_d;
    logic [OUT_AW-1:0]               o_q, o_d;
    logic [W_AW-1:0]                 base_q, base_d;
    logic                            acc_vld_q, acc_vld_d;
    logic [OUTPUT_DIM*ACC_BIT-1:0]   acc_q, acc_d;
    logic [OUTPUT_DIM*BIT_CNT-1:0]   out_data_q, out_data_d;
    logic [OUT_AW-1:0]               out_tile_q, out_tile_d;
    logic                            done_q, done_d;

    logic                            acc_clr;
    logic [OUTPUT_DIM*BIT_CNT-1:0]   lane_res;
    logic                            cfg_ok;
    logic                            last_k;
    logic                            last_o;

    assign cfg_ok = (cfg_in_tiles != '0) && (cfg_out_tiles != '0);
    assign last_k = ({1'b0, k_q} == n_q - NI_W'(1));
    assign last_o = ({1'b0, o_q} == m_q - NO_W'(1));

    // Per-lane accumulate and output-lane formatting. lane_res already
    // includes the partial sum arriving this cycle so DRAIN can register it.
    generate
        for (genvar gi = 0; gi < OUTPUT_DIM; gi++) begin : g_lane
            logic signed [BIT_CNT-1:0] dp_lane;
            logic signed [ACC_BIT-1:0] acc_lane;
            logic signed [ACC_BIT-1:0] acc_sum;

            assign dp_lane  = dp_result[gi*BIT_CNT +: BIT_CNT];
            assign acc_lane = acc_q[gi*ACC_BIT +: ACC_BIT];
            assign acc_sum  = acc_vld_q
                            ? acc_lane + {{(ACC_BIT-BIT_CNT){dp_lane[BIT_CNT-1]}}, dp_lane}
                            : acc_lane;
            assign acc_d[gi*ACC_BIT +: ACC_BIT] = acc_clr ? '0 : acc_sum;
`ifdef SEQ_SATURATE_EN
            localparam logic signed [ACC_BIT-1:0] SAT_MAX = ACC_BIT'((1 << (BIT_CNT-1)) - 1);
            localparam logic signed [ACC_BIT-1:0] SAT_MIN = ~SAT_MAX;
            assign lane_res[gi*BIT_CNT +: BIT_CNT] =
                (acc_sum > SAT_MAX) ? SAT_MAX[BIT_CNT-1:0] :
                (acc_sum < SAT_MIN) ? SAT_MIN[BIT_CNT-1:0] :
                                      acc_sum[BIT_CNT-1:0];
`else
            assign lane_res[gi*BIT_CNT +: BIT_CNT] = acc_sum[BIT_CNT-1:0];
`endif
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && cfg_ok) state_d = S_RUN;
            S_RUN:   if (last_k) state_d = S_DRAIN;
            S_DRAIN: state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = last_o ? S_IDLE : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; addresses read as 0 when idle.
    always_comb begin
        rd_en     = (state_q == S_RUN);
        in_addr   = '0;
        w_addr    = '0;
        if (state_q == S_RUN) begin
            in_addr = k_q;
            w_addr  = base_q + W_AW'(k_q);
        end
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_OUT);
    end

    assign out_data = out_data_q;
    assign out_tile = out_tile_q;
    assign done     = done_q;

    // Counter, accumulator-control and output-register updates.
    always_comb begin
        n_d        = n_q;
        m_d        = m_q;
        k_d        = k_q;
        o_d        = o_q;
        base_d     = base_q;
        acc_clr    = 1'b0;
        done_d     = 1'b0;
        acc_vld_d  = (state_q == S_RUN);
        out_data_d = '0;
        out_tile_d = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        n_d     = cfg_in_tiles;
                        m_d     = cfg_out_tiles;
                        k_d     = '0;
                        o_d     = '0;
                        base_d  = '0;
                        acc_clr = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                k_d = k_q + IN_AW'(1);
            end
            S_DRAIN: begin
                out_data_d = lane_res;
                out_tile_d = o_q;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_o) begin
                        done_d  = 1'b1;
                    end else begin
                        o_d     = o_q + OUT_AW'(1);
                        k_d     = '0;
                        base_d  = base_q + W_AW'(n_q);
                        acc_clr = 1'b1;
                    end
                end else begin
                    out_data_d = out_data_q;
                    out_tile_d = out_tile_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any layer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            m_q        <= '0;
            k_q        <= '0;
            o_q        <= '0;
            base_q     <= '0;
            acc_vld_q  <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_tile_q <= '0;
            done_q     <= 1'b0;
        end else begin
            n_q        <= n_d;
            m_q        <= m_d;
            k_q        <= k_d;
            o_q        <= o_d;
            base_q     <= base_d;
            acc_vld_q  <= acc_vld_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_tile_q <= out_tile_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Testbench for bnn_layer_sequencer: directed layers with hand-computed
// results; expected read addresses and output tiles are queued by the
// stimulus and consumed by an independent monitor.
module tb_bnn_layer_sequencer;

    localparam int OD = 8;
    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          start;
    logic [4:0]    cfg_in_tiles;
    logic [4:0]    cfg_out_tiles;
    logic          rd_en;
    logic [3:0]    in_addr;
    logic [7:0]    w_addr;
    logic [DW-1:0] dp_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_tile;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [3:0]    tile;
        logic [DW-1:0] data;
    } out_exp_t;

    typedef struct packed {
        logic [3:0] ia;
        logic [7:0] wa;
    } addr_exp_t;

    out_exp_t      out_q[$];
    addr_exp_t     addr_q[$];
    logic [DW-1:0] dp_vec [256];
    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            bp_left  = 0;
    bit            mon_en   = 0;

    bnn_layer_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_in_tiles  (cfg_in_tiles),
        .cfg_out_tiles (cfg_out_tiles),
        .rd_en         (rd_en),
        .in_addr       (in_addr),
        .w_addr        (w_addr),
        .dp_result     (dp_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_tile      (out_tile),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath + memories model: result appears the cycle after rd_en,
    // filler otherwise so stray accumulation shows up.
    always @(posedge clk) begin
        if (rd_en) dp_result <= dp_vec[w_addr];
        else       dp_result <= {OD{8'h33}};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic set_tile(input int addr, input logic [7:0] v);
        dp_vec[addr] = {OD{v}};
    endtask

    task automatic push_addr(input int ia, input int wa);
        addr_exp_t e;
        e.ia = 4'(ia);
        e.wa = 8'(wa);
        addr_q.push_back(e);
    endtask

    task automatic push_out(input int tile, input logic [DW-1:0] data);
        out_exp_t e;
        e.tile = 4'(tile);
        e.data = data;
        out_q.push_back(e);
    endtask

    // Back-pressure driver: holds out_ready low for bp_left valid cycles.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (out_valid && bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: checks read addresses and output tiles against the queues,
    // output stability under back-pressure and zero data while not valid.
    initial begin
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic [3:0]    prev_tile;
        addr_exp_t     ea;
        out_exp_t      eo;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_tile  = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_en) begin
                    if (addr_q.size() == 0) begin
                        fail_now("unexpected_rd_en");
                    end else begin
                        ea = addr_q.pop_front();
                        check("in_addr", in_addr, ea.ia);
                        check("w_addr", w_addr, ea.wa);
                    end
                end
                if (out_valid && prev_stall) begin
                    check("stall_data_stable", out_data, prev_data);
                    check("stall_tile_stable", out_tile, prev_tile);
                end
                if (out_valid && !out_ready) check("stall_rd_en_low", rd_en, 1'b0);
                if (!out_valid) check("idle_out_data_zero", out_data, '0);
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        eo = out_q.pop_front();
                        check("out_tile", out_tile, eo.tile);
                        check("out_data", out_data, eo.data);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_tile  = out_tile;
            end
        end
    end

    // Issue one layer (start in cycle 0) and check cycle-level timing.
    task automatic run_layer(input string tag, input int n, input int m, input int restart_at,
                             input int exp_rd, input int exp_valid_c, input int exp_done_c);
        int rd_cnt;
        int done_cnt;
        int first_v;
        int done_c;
        bit fin;
        bit busy_at_done;
        bit busy_c1;
        rd_cnt = 0; done_cnt = 0; first_v = -1; done_c = -1;
        fin = 1'b0; busy_at_done = 1'b1; busy_c1 = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_in_tiles  = 5'(n);
        cfg_out_tiles = 5'(m);
        for (int c = 1; c <= 300 && !fin; c++) begin
            @(posedge clk); #1;
            start = (c == restart_at);
            if (start) begin
                cfg_in_tiles  = 5'd1;
                cfg_out_tiles = 5'd1;
            end
            @(negedge clk);
            if (c == 1) busy_c1 = busy;
            if (rd_en) rd_cnt++;
            if (out_valid && first_v < 0) first_v = c;
            if (done) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c = c;
                    busy_at_done = busy;
                end
            end
            if (done_c >= 0 && c >= done_c + 3) fin = 1'b1;
        end
        start = 1'b0;
        if (done_c < 0) $display("FAIL %s_timeout: got no done, expected done at cycle %0d", tag, exp_done_c);
        check({tag, "_rd_count"}, rd_cnt, exp_rd);
        check({tag, "_first_valid_cycle"}, first_v, exp_valid_c);
        check({tag, "_done_cycle"}, done_c, exp_done_c);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
        check({tag, "_busy_cycle1"}, busy_c1, exp_rd > 0);
        check({tag, "_addr_queue_left"}, addr_q.size(), 0);
        check({tag, "_out_queue_left"}, out_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_in_tiles = '0;
        cfg_out_tiles = '0;
        for (int i = 0; i < 256; i++) dp_vec[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_in_addr", in_addr, '0);
        check("rst_w_addr", w_addr, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_tile", out_tile, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // N=3, M=1, lanes 10 -> 30
        for (int k = 0; k < 3; k++) begin set_tile(k, 8'd10); push_addr(k, k); end
        push_out(0, {OD{8'd30}});
        run_layer("t1", 3, 1, 0, 3, 5, 6);

        // N=2, M=3, lane value o+1 -> 2, 4, 6
        set_tile(0, 8'd1); set_tile(1, 8'd1);
        set_tile(2, 8'd2); set_tile(3, 8'd2);
        set_tile(4, 8'd3); set_tile(5, 8'd3);
        push_addr(0, 0); push_addr(1, 1);
        push_addr(0, 2); push_addr(1, 3);
        push_addr(0, 4); push_addr(1, 5);
        push_out(0, {OD{8'd2}});
        push_out(1, {OD{8'd4}});
        push_out(2, {OD{8'd6}});
        run_layer("t2", 2, 3, 0, 6, 4, 13);

        // N=16, lanes 100 -> 1600: clamp 127 or wrap 64
        for (int k = 0; k < 16; k++) begin set_tile(k, 8'd100); push_addr(k, k); end
`ifdef SEQ_SATURATE_EN
        push_out(0, {OD{8'd127}});
`else
        push_out(0, {OD{8'd64}});
`endif
        run_layer("t3", 16, 1, 0, 16, 18, 19);

        // Lane ordering: (l-4) + l = 2l-4 per lane
        dp_vec[0] = 64'h03020100_FFFEFDFC;
        dp_vec[1] = 64'h07060504_03020100;
        push_addr(0, 0); push_addr(1, 1);
        push_out(0, 64'h0A080604_0200FEFC);
        run_layer("t4", 2, 1, 0, 2, 4, 5);

        // Lanes -5, N=4 -> -20, consumer stalls 4 cycles
        for (int k = 0; k < 4; k++) begin set_tile(k, 8'hFB); push_addr(k, k); end
        push_out(0, {OD{8'hEC}});
        bp_left = 4;
        run_layer("t5", 4, 1, 0, 4, 6, 11);

        // Second start during RUN is ignored: N=3 lanes 7 -> 21
        for (int k = 0; k < 3; k++) begin set_tile(k, 8'd7); push_addr(k, k); end
        push_out(0, {OD{8'd21}});
        run_layer("t6", 3, 1, 2, 3, 5, 6);

        // Zero-sized layers: no reads, done in cycle 1
        run_layer("t7", 0, 2, 0, 0, -1, 1);
        run_layer("t8", 3, 0, 0, 0, -1, 1);

        // Reset during RUN at cycle 2 aborts the layer
        for (int k = 0; k < 4; k++) set_tile(k, 8'd9);
        push_addr(0, 0); push_addr(1, 1);
        @(posedge clk); #1;
        start = 1'b1; cfg_in_tiles = 5'd4; cfg_out_tiles = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_c2", busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_rd_en", rd_en, 1'b0);
        check("abort_in_addr", in_addr, '0);
        check("abort_w_addr", w_addr, '0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_data", out_data, '0);
        check("abort_out_tile", out_tile, '0);
        check("abort_done", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end
        check("abort_addr_queue_left", addr_q.size(), 0);

        // Fresh layer after the abort: N=2 lanes 9 -> 18
        for (int k = 0; k < 2; k++) push_addr(k, k);
        push_out(0, {OD{8'd18}});
        run_layer("t9", 2, 1, 0, 2, 4, 5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bnn_layer_sequencer.md
# bnn_layer_sequencer

Sequencer that tiles one fully-connected binary-weight layer over the combinational fixed-point-input / binary-weight datapath. It walks input tiles and output tiles, issues read addresses to the input buffer and weight memory, and accumulates the datapath's per-tile partial sums in wide signed accumulators. Each finished output tile is presented on a valid/ready stream. It sits between the layer-level control (start/done) and the datapath plus its two memories.

## Interface
- `INPUT_DIM`, 16, inputs per tile (datapath width)
- `OUTPUT_DIM`, 8, output lanes per tile
- `BIT_CNT`, 8, signed bit width of datapath lanes and output lanes
- `MAX_IN_TILES`, 16, maximum input tiles per layer
- `MAX_OUT_TILES`, 16, maximum output tiles per layer
- `ACC_BIT`, 16, signed accumulator width per lane (≥ BIT_CNT + clog2(MAX_IN_TILES))

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle layer start; sampled only in IDLE
- `cfg_in_tiles`  in  clog2(MAX_IN_TILES)+1  input tile count N, sampled with start
- `cfg_out_tiles`  in  clog2(MAX_OUT_TILES)+1  output tile count M, sampled with start
- `rd_en`  out  1  read strobe to input buffer and weight memory
- `in_addr`  out  clog2(MAX_IN_TILES)  input tile index k
- `w_addr`  out  clog2(MAX_IN_TILES*MAX_OUT_TILES)  weight tile index o*N+k
- `dp_result`  in  OUTPUT_DIM*BIT_CNT  datapath output, signed lanes; valid the cycle after rd_en
- `out_valid`  out  1  output tile available
- `out_ready`  in  1  consumer accepts
- `out_data`  out  OUTPUT_DIM*BIT_CNT  signed output lanes
- `out_tile`  out  clog2(MAX_OUT_TILES)  output tile index o
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse when the layer completes

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE: on `start` with N≥1 and M≥1, latch N and M, set o=0, k=0, clear accumulators, and enter RUN. If `start` arrives with N=0 or M=0, issue no reads, pulse `done` next cycle, and stay in IDLE.
- RUN: assert `rd_en` every cycle with `in_addr`=k and `w_addr`=o*N+k, and increment k. After issuing k=N-1, enter DRAIN.
- Accumulate: in every cycle following an `rd_en` cycle, each lane does acc += sign-extended `dp_result` lane.
- DRAIN: absorb the last partial sum, then enter OUT.
- OUT: `out_valid`=1, with `out_data` derived from the accumulators and `out_tile`=o. On `out_valid`&&`out_ready`:
  - if o<M-1: o++, k=0, clear accumulators, enter RUN;
  - else: pulse `done` and enter IDLE.
- Accumulator arithmetic wraps modulo 2^ACC_BIT. Out-of-range values are a configuration error; the bench must not produce them.
- `start` outside IDLE is ignored.
- Synchronous `rst` in any state forces IDLE immediately and aborts the layer. No `done` pulse is produced, and partial results are discarded.

## Timing
- Reset values: `rd_en`=0, `in_addr`=0, `w_addr`=0, `out_valid`=0, `out_data`=0, `out_tile`=0, `busy`=0, `done`=0. Accumulators and counters are 0.
- `start` sampled at cycle 0:
  - `rd_en` in cycles 1..N;
  - accumulation in cycles 2..N+1 (DRAIN = cycle N+1);
  - `out_valid` rises at cycle N+2.
- Per-tile latency from RUN entry to `out_valid` is N+1 cycles.
- Under back-pressure, OUT holds `out_valid`, `out_data` and `out_tile` stable and `rd_en`=0.
- Next tile: the handshake at cycle t puts RUN at t+1.
- `done` is asserted in the cycle after the final handshake, with `busy`=0 in that same cycle.
- `out_data` and `out_tile` are registered; `out_data` is held at 0 while `out_valid`=0.

## Configuration
- `SEQ_SATURATE_EN` defined: each `out_data` lane is the accumulator clamped to [-2^(BIT_CNT-1), 2^(BIT_CNT-1)-1].
- `SEQ_SATURATE_EN` not defined: each lane is the low BIT_CNT bits of the accumulator (two's-complement wrap).

## Test plan
- N=3, M=1, every `dp_result` lane = 10 → `rd_en` in cycles 1–3 with `w_addr` 0,1,2; `out_valid` at cycle 5 with all lanes 30, `out_tile`=0; `done` after the handshake.
- N=2, M=3, `out_ready` tied high, lane value = o+1 → `w_addr` sequence 0,1,2,3,4,5; outputs 2, 4, 6 for tiles 0, 1, 2; exactly one `done` pulse.
- N=16, M=1, lanes = 100 → with `SEQ_SATURATE_EN` all lanes = 127; without it all lanes = 64 (1600 mod 256).
- Lanes = -5 with N=4 → -20; `out_ready` held low 4 cycles → `out_valid`, `out_data` and `out_tile` stable, `rd_en`=0 throughout; accepted on the 5th cycle.
- `start` pulsed again during RUN → ignored, and the result matches the single-start case. `start` with N=0 → no `rd_en`, and `done` at cycle 1.
- `rst` asserted during RUN at cycle 2 → next cycle `busy`=0 with all outputs at reset values. A subsequent `start` produces correct results with no residue from the aborted layer.
